muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle HI/LO multiply/divide unit; option macro MULDIV_DIVZERO_FAST_EN
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      control,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    output logic            o,
    output logic            z
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_div, neg_q, neg_r, div0, ovf;
    logic [XLEN-1:0]   opd, a_raw;
    logic [2*XLEN-1:0] acc, acc_next, prod;
    logic [XLEN-1:0]   mag1, mag2, quo, rem, res_lo, res_hi;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              res_o;

    always_comb begin
        mag1 = (control[1] && in1[XLEN-1]) ? -in1 : in1;
        mag2 = (control[1] && in2[XLEN-1]) ? -in2 : in2;
    end

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opd};
        if (!op_div)
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op_div) begin
            res_lo = prod[XLEN-1:0];
            res_hi = prod[2*XLEN-1:XLEN];
            res_o  = 1'b0;
        end else if (div0) begin
            res_lo = '1;
            res_hi = a_raw;
            res_o  = 1'b1;
        end else begin
            res_lo = quo;
            res_hi = rem;
            res_o  = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            out1   <= '0;
            out2   <= '0;
            o      <= 1'b0;
            z      <= 1'b0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            opd    <= '0;
            a_raw  <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && control[3:2] == 2'b11) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        op_div <= control[0];
                        neg_q  <= control[1] & (in1[XLEN-1] ^ in2[XLEN-1]);
                        neg_r  <= control[1] & control[0] & in1[XLEN-1];
                        div0   <= control[0] && (in2 == '0);
                        ovf    <= control[1] && control[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}})
                                  && (in2 == '1);
                        opd    <= control[0] ? mag2 : mag1;
                        acc    <= {{XLEN{1'b0}}, (control[0] ? mag1 : mag2)};
                        a_raw  <= in1;
                        state  <= RUN;
`ifdef MULDIV_DIVZERO_FAST_EN
                        if (control[0] && in2 == '0)
                            state <= FIX;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == CW'(XLEN-1))
                        state <= FIX;
                    else
                        cnt <= cnt + 1'b1;
                end
                FIX: begin
                    out1  <= res_lo;
                    out2  <= res_hi;
                    o     <= res_o;
                    z     <= (res_lo == '0) && (res_hi == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
